// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one 32-bit ALU between two requesters:
//     requester 0 is the execute-stage integer path,
//     requester 1 is the address-generation / auxiliary path.
//   Requesters are served round-robin through a one-entry registered
//   result stage. Latency is 1 cycle, and throughput is 1 op/cycle
//   while the owning response consumer is ready.
//
// Ports
//   clk                          clock, rising edge
//   reset                        synchronous, active-high reset
//   req0_valid / req0_ready      requester 0 request handshake
//   req0_control                 ALU_* code for requester 0
//   req0_left / req0_right       operands for requester 0
//   req1_*                       same for requester 1
//   rsp0_valid / rsp0_ready      requester 0 response handshake
//   rsp0_result                  registered result (qualify with rsp0_valid)
//   rsp1_*                       same for requester 1
//   busy                         result register occupied
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | out_valid = 0, result register empty
// FULL  | out_valid = 1, result held for out_owner until it is drained
module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [CTRL_WIDTH-1:0] req0_control,
  input  logic [DATA_WIDTH-1:0] req0_left,
  input  logic [DATA_WIDTH-1:0] req0_right,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [CTRL_WIDTH-1:0] req1_control,
  input  logic [DATA_WIDTH-1:0] req1_left,
  input  logic [DATA_WIDTH-1:0] req1_right,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_result,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_result,
  output logic                  busy
);

  localparam logic [CTRL_WIDTH-1:0] ALU_ADD  = CTRL_WIDTH'(4'h0);
  localparam logic [CTRL_WIDTH-1:0] ALU_SUB  = CTRL_WIDTH'(4'h1);
  localparam logic [CTRL_WIDTH-1:0] ALU_AND  = CTRL_WIDTH'(4'h2);
  localparam logic [CTRL_WIDTH-1:0] ALU_OR   = CTRL_WIDTH'(4'h3);
  localparam logic [CTRL_WIDTH-1:0] ALU_XOR  = CTRL_WIDTH'(4'h4);
  localparam logic [CTRL_WIDTH-1:0] ALU_SLT  = CTRL_WIDTH'(4'h5);
  localparam logic [CTRL_WIDTH-1:0] ALU_SLTU = CTRL_WIDTH'(4'h6);
  localparam logic [CTRL_WIDTH-1:0] ALU_SLL  = CTRL_WIDTH'(4'h7);
  localparam logic [CTRL_WIDTH-1:0] ALU_SRL  = CTRL_WIDTH'(4'h8);
  localparam logic [CTRL_WIDTH-1:0] ALU_SRA  = CTRL_WIDTH'(4'h9);

  logic                  out_valid;
  logic                  out_owner;
  logic [DATA_WIDTH-1:0] out_result;
  logic                  last_grant;

  logic                  drain;
  logic                  can_accept;
  logic                  grant;
  logic                  accept;
  logic [CTRL_WIDTH-1:0] sel_control;
  logic [DATA_WIDTH-1:0] sel_left;
  logic [DATA_WIDTH-1:0] sel_right;
  logic [DATA_WIDTH-1:0] alu_result;

  // Only the owner's consumer can free the result register; the other
  // requester's rsp_ready is deliberately ignored.
  assign drain      = out_valid && (out_owner ? rsp1_ready : rsp0_ready);
  assign can_accept = !out_valid || drain;

  // Round-robin on contention; a lone requester always wins. With no
  // requester the grant value is irrelevant because accept stays low.
  assign grant  = (req0_valid && req1_valid) ? !last_grant : req1_valid;
  assign accept = can_accept && (req0_valid || req1_valid);

  assign req0_ready = can_accept && !grant && req0_valid;
  assign req1_ready = can_accept &&  grant && req1_valid;

  assign sel_control = grant ? req1_control : req0_control;
  assign sel_left    = grant ? req1_left    : req0_left;
  assign sel_right   = grant ? req1_right   : req0_right;

  // Shift amounts use the whole right operand, so amounts >= 32 shift
  // everything out (SRA fills with the sign bit). Unknown codes add.
  always_comb begin
    alu_result = sel_left + sel_right;
    case (sel_control)
      ALU_ADD:  alu_result = sel_left + sel_right;
      ALU_SUB:  alu_result = sel_left - sel_right;
      ALU_AND:  alu_result = sel_left & sel_right;
      ALU_OR:   alu_result = sel_left | sel_right;
      ALU_XOR:  alu_result = sel_left ^ sel_right;
      ALU_SLT:  alu_result = {{(DATA_WIDTH-1){1'b0}},
                              ($signed(sel_left) < $signed(sel_right))};
      ALU_SLTU: alu_result = {{(DATA_WIDTH-1){1'b0}}, (sel_left < sel_right)};
      ALU_SLL:  alu_result = sel_left << sel_right;
      ALU_SRL:  alu_result = sel_left >> sel_right;
      ALU_SRA:  alu_result = $signed(sel_left) >>> sel_right;
      default:  alu_result = sel_left + sel_right;
    endcase
  end

  // A drain and an accept in the same cycle leave the register FULL with
  // the new result, so back-to-back ops see no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_owner  <= 1'b0;
      out_result <= '0;
      last_grant <= 1'b1;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_owner  <= grant;
      out_result <= alu_result;
      last_grant <= grant;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

  assign rsp0_valid  = out_valid && !out_owner;
  assign rsp1_valid  = out_valid &&  out_owner;
  assign rsp0_result = out_result;
  assign rsp1_result = out_result;
  assign busy        = out_valid;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one instance of the team's `alu` datapath between two requesters: requester 0 is the execute-stage integer path, requester 1 is the address-generation / auxiliary path.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin, with a one-entry registered result stage. Latency is 1 cycle and throughput is 1 op/cycle when the response consumer is ready.

Parameters:
- DATA_WIDTH, 32, operand and result width. The shared alu is 32-bit, so only 32 is supported.
- CTRL_WIDTH, 4, width of the ALU control code (ALU_* encodings from common).

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has an op
- req0_ready  output  1  requester 0 op accepted this cycle
- req0_control  input  CTRL_WIDTH  ALU_* code
- req0_left  input  DATA_WIDTH  left operand
- req0_right  input  DATA_WIDTH  right operand
- req1_valid, req1_ready, req1_control, req1_left, req1_right: same directions, widths and meanings for requester 1
- rsp0_valid  output  1  result available for requester 0
- rsp0_ready  input  1  requester 0 consumes result
- rsp0_result  output  DATA_WIDTH  result for requester 0
- rsp1_valid, rsp1_ready, rsp1_result: same for requester 1
- busy  output  1  result register occupied (equals internal out_valid)

Behaviour:
- Internal state:
  - out_valid (1b), out_owner (1b), out_result (DATA_WIDTH).
  - last_grant (1b): the requester granted most recently.
- Reset: out_valid=0, out_owner=0, out_result=0, last_grant=1, so requester 0 wins the first contention.
- Reset is synchronous and takes priority over every other update in the same cycle. A result in flight at reset is discarded and is never presented.
- Drain: drain = out_valid && rspX_ready, where X = out_owner.
- Accept window: can_accept = !out_valid || drain.
  - New work may enter in the same cycle the old result leaves (bubble-free).
- Grant, combinational, evaluated every cycle:
  - Only req0_valid: grant=0.
  - Only req1_valid: grant=1.
  - Both valid: grant = !last_grant.
  - Neither valid: no grant.
- req0_ready = can_accept && grant==0 && req0_valid; req1_ready likewise.
  - At most one ready is high per cycle.
  - Ready never depends on the requester's own ready (no combinational loop). It does depend on rsp_ready of the current owner.
- On accept at edge N:
  - The granted operands/control are driven into the alu combinationally.
  - out_result <= alu result; out_owner <= grant; out_valid <= 1; last_grant <= grant.
- On drain without accept: out_valid <= 0. out_result and out_owner hold their values (don't-care).
- No accept and no drain: all state holds.
- Response routing:
  - rsp0_valid = out_valid && out_owner==0; rsp1_valid = out_valid && out_owner==1.
  - rsp0_result = rsp1_result = out_result. Consumers qualify with their own valid.
- Latency: request accepted at edge N, response valid from N (visible in cycle N+1) until consumed.
- Requester rules (bench asserts, RTL does not check):
  - Once valid is high, payload is held stable and valid stays high until ready.
  - The arbiter may switch grant between cycles while a request waits. Round-robin bounds that wait to one competing op.
- Backpressure:
  - If the owner holds rspX_ready low, the result stays registered with a stable value, and both req_ready stay low.
  - The other requester's rsp_ready has no effect.
- ALU semantics are those of the shared alu. Unknown control codes produce ADD.
  - Shift amounts are the full right operand, not masked. Callers needing RV32 semantics mask to 5 bits before requesting.
- Simultaneous drain + accept by the same requester is legal: the new result replaces the old at the same edge.
- No internal FSM beyond the out_valid register (IDLE = !out_valid, FULL = out_valid). FULL->FULL occurs on drain+accept.

Test Plan:
- After reset, req0 ALU_ADD 5+7 alone -> req0_ready=1 in cycle 0; rsp0_valid=1, rsp0_result=12 in cycle 1; rsp1_valid=0.
- Both requesters valid continuously with rsp ready held 1: req0 ALU_SUB 10-3, req1 ALU_XOR 0xFF^0x0F -> grants alternate 0,1,0,1; results 7 and 0xF0 appear on alternating cycles; no bubbles.
- Backpressure: req1 ALU_SLT 0xFFFFFFFF vs 1 accepted, rsp1_ready=0 for 3 cycles -> rsp1_result=1 stable; req0_ready and req1_ready both 0; on release, new op accepted the same cycle.
- Drain + accept same requester: req0 ALU_SLL 1<<4 then ALU_SRA 0x80000000>>>4 back-to-back with rsp0_ready=1 -> results 0x10 then 0xF8000000 on consecutive cycles.
- Reset mid-operation: accept req0 ALU_OR, assert reset while rsp0_valid=1 and rsp0_ready=0 -> next cycle rsp0_valid=0, busy=0; contention afterward grants requester 0 first.
- Unknown control code 4'hF with operands 2 and 3 -> result 5; rsp_valid routed only to the issuing requester.
